// File: rtl/dt_blue_hit_if.sv
// Signal bundle between the player/slime geometry sources and the blue-hit
// collision block; master drives positions and timing, slave returns hit state.
interface dt_blue_hit_if;
  logic [9:0]  x_blue;
  logic [8:0]  y_blue;
  logic [9:0]  x_slim;
  logic [8:0]  y_slim;
  logic [31:0] ipcnt;
  logic        frozen;
  logic        hit_pulse;
  logic [1:0]  lives;
  logic        invuln;
  logic        blink;
  logic        knock_left;
  logic        dead;

  modport master (
    output x_blue, y_blue, x_slim, y_slim, ipcnt, frozen,
    input  hit_pulse, lives, invuln, blink, knock_left, dead
  );

  modport slave (
    input  x_blue, y_blue, x_slim, y_slim, ipcnt, frozen,
    output hit_pulse, lives, invuln, blink, knock_left, dead
  );
endinterface

// File: rtl/dt_blue_hit.sv
// Slime-damages-player collision: side/bottom contact costs a life, then a tick-timed
// invulnerability window; game-over is sticky. Define DT_BLUE_HIT_BLINK_EN for sprite blink.
module dt_blue_hit #(
  parameter int unsigned BLUE_W     = 47,
  parameter int unsigned BLUE_H     = 41,
  parameter int unsigned SLIM_W     = 62,
  parameter int unsigned SLIM_H     = 36,
  parameter int unsigned STOMP_TOL  = 2,
  parameter int unsigned TICK_AT    = 6000000,
  parameter int unsigned INV_TICKS  = 15,
  parameter int unsigned LIVES_INIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  dt_blue_hit_if.slave bus
);

  localparam logic [10:0] BW_X    = 11'(BLUE_W);
  localparam logic [10:0] SW_X    = 11'(SLIM_W);
  localparam logic [10:0] BW_HALF = 11'(BLUE_W / 2);
  localparam logic [10:0] SW_HALF = 11'(SLIM_W / 2);
  localparam logic [9:0]  BH_Y    = 10'(BLUE_H);
  localparam logic [9:0]  SH_Y    = 10'(SLIM_H);
  localparam logic [9:0]  TOL_Y   = 10'(STOMP_TOL);
  localparam logic [3:0]  INV_LAST = 4'(INV_TICKS - 1);
  localparam logic [1:0]  LIVES_RST = 2'(LIVES_INIT);

  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

  state_t     state_reg, state_next;
  logic [1:0] lives_reg, lives_next;
  logic [3:0] inv_cnt_reg, inv_cnt_next;
  logic       hit_pulse_reg, hit_pulse_next;
  logic       invuln_reg, invuln_next;
  logic       knock_left_reg, knock_left_next;
  logic       dead_reg, dead_next;

  logic [10:0] xb, xs;
  logic [9:0]  yb, ys, blue_bottom, stomp_lo;
  logic        overlap, stomp, contact, tick, knock_calc;

  assign xb = {1'b0, bus.x_blue};
  assign xs = {1'b0, bus.x_slim};
  assign yb = {1'b0, bus.y_blue};
  assign ys = {1'b0, bus.y_slim};
  assign blue_bottom = yb + BH_Y;

  // Stomp band sits just around the slime's top edge; its lower bound saturates at row 0.
  assign stomp_lo = (ys >= TOL_Y) ? (ys - TOL_Y) : 10'd0;

  assign overlap = (xb < xs + SW_X) && (xb + BW_X > xs) &&
                   (yb < ys + SH_Y) && (blue_bottom > ys);
  assign stomp   = (blue_bottom > stomp_lo) && (blue_bottom < ys + TOL_Y);
  assign contact = overlap && !stomp && !bus.frozen;
  assign tick    = (bus.ipcnt == TICK_AT);
  assign knock_calc = (xb + BW_HALF) < (xs + SW_HALF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ALIVE;
      lives_reg      <= LIVES_RST;
      inv_cnt_reg    <= 4'd0;
      hit_pulse_reg  <= 1'b0;
      invuln_reg     <= 1'b0;
      knock_left_reg <= 1'b0;
      dead_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      lives_reg      <= lives_next;
      inv_cnt_reg    <= inv_cnt_next;
      hit_pulse_reg  <= hit_pulse_next;
      invuln_reg     <= invuln_next;
      knock_left_reg <= knock_left_next;
      dead_reg       <= dead_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    lives_next      = lives_reg;
    inv_cnt_next    = inv_cnt_reg;
    hit_pulse_next  = 1'b0;
    invuln_next     = invuln_reg;
    knock_left_next = knock_left_reg;
    dead_next       = dead_reg;
    case (state_reg)
      ALIVE: begin
        // A tick coinciding with a hit is simply dropped: the window starts at zero.
        if (contact) begin
          hit_pulse_next  = 1'b1;
          lives_next      = lives_reg - 2'd1;
          knock_left_next = knock_calc;
          if (lives_reg == 2'd1) begin
            state_next  = DEAD;
            dead_next   = 1'b1;
            invuln_next = 1'b0;
          end else begin
            state_next   = INVULN;
            inv_cnt_next = 4'd0;
            invuln_next  = 1'b1;
          end
        end
      end
      INVULN: begin
        if (tick) begin
          if (inv_cnt_reg == INV_LAST) begin
            state_next   = ALIVE;
            inv_cnt_next = 4'd0;
            invuln_next  = 1'b0;
          end else begin
            inv_cnt_next = inv_cnt_reg + 4'd1;
          end
        end
      end
      DEAD: begin
        dead_next   = 1'b1;
        invuln_next = 1'b0;
        lives_next  = 2'd0;
      end
      default: state_next = ALIVE;
    endcase
  end

`ifdef DT_BLUE_HIT_BLINK_EN
  logic blink_reg, blink_next;

  // Blink phase restarts dark at both ends of the window so the sprite never ends hidden.
  always_comb begin
    blink_next = 1'b0;
    if (state_reg == INVULN) begin
      blink_next = blink_reg;
      if (tick) begin
        blink_next = (inv_cnt_reg == INV_LAST) ? 1'b0 : ~blink_reg;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_reg <= 1'b0;
    end else begin
      blink_reg <= blink_next;
    end
  end

  assign bus.blink = blink_reg;
`else
  assign bus.blink = 1'b0;
`endif

  assign bus.hit_pulse  = hit_pulse_reg;
  assign bus.lives      = lives_reg;
  assign bus.invuln     = invuln_reg;
  assign bus.knock_left = knock_left_reg;
  assign bus.dead       = dead_reg;

endmodule

// File: tb/tb_dt_blue_hit.sv
// Directed plus randomized bench for dt_blue_hit against a countdown-style reference model.
module tb_dt_blue_hit;
  localparam int BLUE_W = 47, BLUE_H = 41, SLIM_W = 62, SLIM_H = 36;
  localparam int STOMP_TOL = 2, INV_TICKS = 15, LIVES_INIT = 3;
  localparam int unsigned TICK_AT = 6000000;
`ifdef DT_BLUE_HIT_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  dt_blue_hit_if bus();

  dt_blue_hit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // reference model: lives as an integer, window as ticks remaining
  int m_lives, m_inv_left;
  bit m_hit, m_dead, m_knock, m_blink;

  function automatic bit contact_ref(int xb, int yb, int xs, int ys, bit fr);
    bit ov, st;
    int lo;
    ov = (xb < xs + SLIM_W) && (xb + BLUE_W > xs) && (yb < ys + SLIM_H) && (yb + BLUE_H > ys);
    lo = (ys - STOMP_TOL < 0) ? 0 : ys - STOMP_TOL;
    st = (yb + BLUE_H > lo) && (yb + BLUE_H < ys + STOMP_TOL);
    return ov && !st && !fr;
  endfunction

  function automatic void model_reset();
    m_lives = LIVES_INIT; m_inv_left = 0;
    m_hit = 0; m_dead = 0; m_knock = 0; m_blink = 0;
  endfunction

  function automatic void model_step();
    bit c, t;
    int xb, xs;
    if (rst) begin model_reset(); return; end
    xb = int'(bus.x_blue); xs = int'(bus.x_slim);
    c = contact_ref(xb, int'(bus.y_blue), xs, int'(bus.y_slim), bus.frozen);
    t = (bus.ipcnt == TICK_AT);
    m_hit = 0;
    if (m_dead) begin
      m_lives = 0;
    end else if (m_inv_left > 0) begin
      if (t) begin
        m_inv_left--;
        m_blink = (m_inv_left == 0) ? 1'b0 : ~m_blink;
      end
    end else if (c) begin
      m_hit = 1;
      m_lives--;
      m_knock = (xb + BLUE_W / 2) < (xs + SLIM_W / 2);
      m_blink = 0;
      if (m_lives == 0) m_dead = 1;
      else m_inv_left = INV_TICKS;
    end
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic compare_all(string tag);
    check({tag, ".hit_pulse"}, 32'(bus.hit_pulse), 32'(m_hit));
    check({tag, ".lives"}, 32'(bus.lives), 32'(m_lives));
    check({tag, ".invuln"}, 32'(bus.invuln), 32'(m_inv_left > 0 && !m_dead));
    check({tag, ".dead"}, 32'(bus.dead), 32'(m_dead));
    check({tag, ".knock_left"}, 32'(bus.knock_left), 32'(m_knock));
    check({tag, ".blink"}, 32'(bus.blink), 32'(BLINK_EN & m_blink));
  endtask

  task automatic cycle(string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic tick_cycle(string tag);
    bus.ipcnt = TICK_AT;
    cycle(tag);
    bus.ipcnt = 32'd0;
  endtask

  task automatic set_geo(int xb, int yb, int xs, int ys, bit fr);
    bus.x_blue = 10'(xb); bus.y_blue = 9'(yb);
    bus.x_slim = 10'(xs); bus.y_slim = 9'(ys);
    bus.frozen = fr;
  endtask

  // expire an invulnerability window with a few quiet cycles between ticks
  task automatic run_ticks(int n, string tag);
    for (int i = 0; i < n; i++) begin
      cycle(tag); cycle(tag);
      tick_cycle(tag);
    end
  endtask

  initial begin
    bus.ipcnt = 32'd0;
    set_geo(130, 154, 130, 195, 1'b0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("reset.lives", 32'(bus.lives), 32'd3);
    check("reset.hit", 32'(bus.hit_pulse), 32'd0);
    check("reset.invuln", 32'(bus.invuln), 32'd0);
    check("reset.dead", 32'(bus.dead), 32'd0);
    check("reset.knock", 32'(bus.knock_left), 32'd0);
    check("reset.blink", 32'(bus.blink), 32'd0);
    rst = 1'b0;

    // stomp from above: bottom edge level with slime top
    for (int i = 0; i < 5; i++) cycle("stomp");
    check("stomp.lives", 32'(bus.lives), 32'd3);

    // side contact while frozen, then thaw
    set_geo(100, 200, 130, 195, 1'b1);
    for (int i = 0; i < 100; i++) cycle("frozen");
    check("frozen.lives", 32'(bus.lives), 32'd3);
    bus.frozen = 1'b0;
    cycle("side");
    check("side.hit", 32'(bus.hit_pulse), 32'd1);
    check("side.lives", 32'(bus.lives), 32'd2);
    check("side.invuln", 32'(bus.invuln), 32'd1);
    check("side.knock", 32'(bus.knock_left), 32'd1);
    cycle("side_pulse_end");
    check("side.hit_end", 32'(bus.hit_pulse), 32'd0);

    // contact held through window: 14 ticks keep invuln, 15th releases, then re-hit
    run_ticks(14, "window");
    check("window14.invuln", 32'(bus.invuln), 32'd1);
    check("window14.lives", 32'(bus.lives), 32'd2);
    tick_cycle("window15");
    check("window15.invuln", 32'(bus.invuln), 32'd0);
    cycle("rehit");
    check("rehit.hit", 32'(bus.hit_pulse), 32'd1);
    check("rehit.lives", 32'(bus.lives), 32'd1);

    // separate, let window expire, then the fatal hit from the left side
    set_geo(0, 200, 130, 195, 1'b0);
    run_ticks(15, "sep");
    set_geo(160, 200, 130, 195, 1'b0);
    cycle("fatal");
    check("fatal.lives", 32'(bus.lives), 32'd0);
    check("fatal.dead", 32'(bus.dead), 32'd1);
    check("fatal.knock", 32'(bus.knock_left), 32'd0);
    run_ticks(6, "dead_hold");
    check("dead_hold.dead", 32'(bus.dead), 32'd1);
    check("dead_hold.lives", 32'(bus.lives), 32'd0);

    // async reset in the middle of a window, between clock edges
    rst = 1'b1; cycle("rst2"); rst = 1'b0;
    set_geo(100, 200, 130, 195, 1'b0);
    cycle("hit3");
    run_ticks(7, "mid");
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("async.lives", 32'(bus.lives), 32'd3);
    check("async.invuln", 32'(bus.invuln), 32'd0);
    check("async.dead", 32'(bus.dead), 32'd0);
    #2 rst = 1'b0;
    set_geo(0, 0, 500, 300, 1'b0);
    cycle("post_async");

    // randomized phase near the slime, including the stomp band and sporadic resets
    for (int i = 0; i < 3000; i++) begin
      int xs, ys, xb, yb;
      if ($urandom_range(0, 3) == 0) begin
        xs = $urandom_range(0, 900); ys = $urandom_range(0, 450);
        xb = xs + int'($urandom_range(0, 160)) - 80;
        if ($urandom_range(0, 3) == 0) yb = ys - BLUE_H + int'($urandom_range(0, 4)) - 2;
        else yb = ys + int'($urandom_range(0, 110)) - 60;
        if (xb < 0) xb = 0;
        if (xb > 1023) xb = 1023;
        if (yb < 0) yb = 0;
        if (yb > 511) yb = 511;
        set_geo(xb, yb, xs, ys, $urandom_range(0, 7) == 0);
      end
      bus.ipcnt = ($urandom_range(0, 2) == 0) ? TICK_AT : $urandom;
      rst = ($urandom_range(0, 249) == 0);
      cycle("rand");
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/dt_blue_hit.md
Name: dt_blue_hit

Overview:
- Reverse-direction collision block to the slime-freeze detector: the slime damages the player (blue) on side or bottom contact.
- The player stomping the slime from above does not cause a hit.
- Tracks remaining lives, runs a tick-timed invulnerability window after each hit and latches game-over.
- Sits beside the slime freeze logic; outputs feed the player-motion (knockback), VGA sprite (blink) and HUD/game-state logic.

Parameters:
BLUE_W, 47, player sprite width in pixels
BLUE_H, 41, player sprite height in pixels
SLIM_W, 62, slime sprite width in pixels
SLIM_H, 36, slime sprite height in pixels
STOMP_TOL, 2, vertical tolerance (px) of the stomp band at slime top
TICK_AT, 6000000, ipcnt value that marks one game tick
INV_TICKS, 15, invulnerability length in ticks (1..15)
LIVES_INIT, 3, lives after reset (1..3)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
x_blue  in  10  player left x
y_blue  in  9  player top y
x_slim  in  10  slime left x
y_slim  in  9  slime top y
ipcnt  in  32  free-running frame/tick counter shared with the freeze logic
frozen  in  1  slime frozen flag from the freeze detector
hit_pulse  out  1  one-cycle strobe per accepted hit
lives  out  2  remaining lives
invuln  out  1  high during invulnerability window
blink  out  1  sprite-hide request during invulnerability
knock_left  out  1  knockback direction of last hit (1 = push player left)
dead  out  1  game-over, sticky

Behaviour:
- Reset (async, rst=1): state=ALIVE, lives=LIVES_INIT, hit_pulse=0, invuln=0, blink=0, knock_left=0, dead=0, inv_cnt=0. All outputs are registered.
- Arithmetic: x sums in 11 bits, y sums in 10 bits, zero-extended. No wrap. The stomp lower bound y_slim-STOMP_TOL clamps at 0.
- overlap = x_blue < x_slim+SLIM_W && x_blue+BLUE_W > x_slim && y_blue < y_slim+SLIM_H && y_blue+BLUE_H > y_slim (strict).
- stomp = (y_blue+BLUE_H > y_slim-STOMP_TOL) && (y_blue+BLUE_H < y_slim+STOMP_TOL).
- contact = overlap && !stomp && !frozen.
- tick = (ipcnt == TICK_AT), single-cycle qualifier.
- State ALIVE: on contact:
  - lives <= lives-1.
  - hit_pulse=1 for exactly the next cycle.
  - knock_left <= (x_blue+BLUE_W/2 < x_slim+SLIM_W/2).
  - If lives==1, go to DEAD; otherwise go to INVULN with inv_cnt=0 and invuln=1.
- State INVULN: contact is ignored. On each tick, inv_cnt increments. The tick on which inv_cnt==INV_TICKS-1 returns the block to ALIVE with invuln=0 and inv_cnt=0.
- State DEAD: dead=1, invuln=0, blink=0, lives=0. Exits only on rst.
- Latency: contact at edge N produces hit_pulse, lives, state and knock_left updates visible after edge N. hit_pulse deasserts after edge N+1.
- Tick and contact in the same ALIVE cycle: the hit is taken; that tick is not counted toward the window.
- Contact held through the end of the window: a new hit is accepted on the first ALIVE cycle.
- frozen rising mid-contact: no hit is taken while frozen=1.
- rst mid-window: immediate return to the reset values above.

Optional Feature:
- Macro: DT_BLUE_HIT_BLINK_EN.
- Defined: blink toggles on every tick while in INVULN. blink is forced to 0 on entry to INVULN and on exit from INVULN.
- Not defined: blink is constant 0. No blink flop is synthesised.

Test Plan:
- Side contact: x_blue=100, y_blue=200, x_slim=130, y_slim=195, frozen=0 -> hit_pulse for 1 cycle; lives 3->2; invuln=1; knock_left=1 (player center 123 < slime center 161).
- Stomp: x_blue=130, y_blue=154 (bottom=195=y_slim), x_slim=130, y_slim=195 -> no hit_pulse; lives stays 3.
- Frozen slime, side contact held 100 cycles with frozen=1 -> no hit; frozen drops to 0 -> hit on the next edge.
- Invulnerability: after a hit, hold contact and drive 14 ticks -> no further hit, invuln=1. On the 15th tick invuln=0, then a second hit follows; lives=1. With DT_BLUE_HIT_BLINK_EN defined, blink toggles on each tick during the window.
- Game over: three separated hits -> lives=0, dead=1 after the third. Further contacts and ticks leave lives and dead unchanged.
- Async reset mid-window (rst pulse between clk edges at tick 7) -> lives=3, invuln=0, dead=0 immediately, without waiting for a clk edge.
